// File: rtl/somador_3bits_bcd.sv
// Three-digit packed-BCD adder with decimal carry-in/carry-out and registered outputs.
// Ripple of three digit cells (units -> tens -> hundreds); Y/Cout update on every rising clk.
module somador_3bits_bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] A,
  input  logic [11:0] B,
  input  logic        Cin,
  output logic [11:0] Y,
  output logic        Cout
);

  // Returns {carry_out, digit}. Non-decimal nibbles follow the same rule, so the result is never X.
  function automatic logic [4:0] digit_cell(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] s;
    logic [4:0] adj;
    s   = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    adj = s + 5'd6;
    if (s > 5'd9) begin
      return {1'b1, adj[3:0]};
    end else begin
      return {1'b0, s[3:0]};
    end
  endfunction

  logic [4:0]  cell0_s;
  logic [4:0]  cell1_s;
  logic [4:0]  cell2_s;
  logic [11:0] sum_s;
  logic        cout_s;
  logic [11:0] y_r;
  logic        cout_r;

  // Ripple-carry chain of the three digit cells
  always_comb begin
    cell0_s = digit_cell(A[3:0],  B[3:0],  Cin);
    cell1_s = digit_cell(A[7:4],  B[7:4],  cell0_s[4]);
    cell2_s = digit_cell(A[11:8], B[11:8], cell1_s[4]);
    sum_s   = {cell2_s[3:0], cell1_s[3:0], cell0_s[3:0]};
    cout_s  = cell2_s[4];
  end

  // Output registers, cleared immediately by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r    <= 12'h000;
      cout_r <= 1'b0;
    end else begin
      y_r    <= sum_s;
      cout_r <= cout_s;
    end
  end

  assign Y    = y_r;
  assign Cout = cout_r;

endmodule

// File: tb/tb_somador_3bits_bcd.sv
// Self-checking bench for somador_3bits_bcd: directed table, reset and pipeline sequences,
// exhaustive single-digit sweep and random operands against a decimal reference model.
module tb_somador_3bits_bcd;

  logic        clk;
  logic        rst_n;
  logic [11:0] A;
  logic [11:0] B;
  logic        Cin;
  logic [11:0] Y;
  logic        Cout;

  int checks;
  int failures;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        cin;
    logic [11:0] y;
    logic        cout;
  } vec_t;

  vec_t tbl[12];

  somador_3bits_bcd dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .Y    (Y),
    .Cout (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bcd_val(input logic [11:0] x);
    return int'(x[11:8]) * 100 + int'(x[7:4]) * 10 + int'(x[3:0]);
  endfunction

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    r[11:8] = 4'((v / 100) % 10);
    r[7:4]  = 4'((v / 10) % 10);
    r[3:0]  = 4'(v % 10);
    return r;
  endfunction

  // Literal digit rule on integers, used for non-decimal nibbles
  function automatic logic [12:0] rule_add(input logic [11:0] a, input logic [11:0] b, input logic c);
    logic [11:0] y;
    int carry;
    int s;
    carry = int'(c);
    for (int d = 0; d < 3; d++) begin
      s = int'(a[d*4 +: 4]) + int'(b[d*4 +: 4]) + carry;
      if (s > 9) begin
        y[d*4 +: 4] = 4'((s + 6) % 16);
        carry = 1;
      end else begin
        y[d*4 +: 4] = 4'(s);
        carry = 0;
      end
    end
    return {carry[0], y};
  endfunction

  task automatic check(input string name, input logic [11:0] y_exp, input logic c_exp);
    checks++;
    if (Y !== y_exp || Cout !== c_exp) begin
      failures++;
      $display("FAIL %s: got Y=%h Cout=%b, expected Y=%h Cout=%b", name, Y, Cout, y_exp, c_exp);
    end
  endtask

  task automatic apply_check(input string name, input logic [11:0] a, input logic [11:0] b,
                             input logic c, input logic [11:0] y_exp, input logic c_exp);
    A   = a;
    B   = b;
    Cin = c;
    @(posedge clk);
    #1;
    check(name, y_exp, c_exp);
  endtask

  initial begin
    int sum;
    logic [11:0] ra;
    logic [11:0] rb;
    logic        rc;
    logic [12:0] rr;
    logic [11:0] pa[6];
    logic [11:0] pb[6];
    logic [11:0] py[6];
    logic        pc[6];

    checks   = 0;
    failures = 0;

    tbl[0]  = '{12'h000, 12'h000, 1'b0, 12'h000, 1'b0};
    tbl[1]  = '{12'h001, 12'h002, 1'b0, 12'h003, 1'b0};
    tbl[2]  = '{12'h001, 12'h003, 1'b1, 12'h005, 1'b0};
    tbl[3]  = '{12'h010, 12'h004, 1'b0, 12'h014, 1'b0};
    tbl[4]  = '{12'h999, 12'h001, 1'b0, 12'h000, 1'b1};
    tbl[5]  = '{12'h999, 12'h999, 1'b0, 12'h998, 1'b1};
    tbl[6]  = '{12'h999, 12'h999, 1'b1, 12'h999, 1'b1};
    tbl[7]  = '{12'h058, 12'h047, 1'b0, 12'h105, 1'b0};
    tbl[8]  = '{12'h00F, 12'h00F, 1'b1, 12'h015, 1'b0};
    tbl[9]  = '{12'hA00, 12'h000, 1'b0, 12'h000, 1'b1};
    tbl[10] = '{12'h0C0, 12'h050, 1'b0, 12'h170, 1'b0};
    tbl[11] = '{12'h500, 12'h499, 1'b1, 12'h000, 1'b1};

    // Reset held with operands present
    rst_n = 1'b0;
    A     = 12'h123;
    B     = 12'h456;
    Cin   = 1'b0;
    #1;
    check("reset_initial", 12'h000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", 12'h000, 1'b0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", 12'h579, 1'b0);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      apply_check($sformatf("table_%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].y, tbl[i].cout);
    end

    // Back-to-back stream: each result must appear one edge after its operands
    pa = '{12'h123, 12'h999, 12'h050, 12'h777, 12'h001, 12'h456};
    pb = '{12'h321, 12'h002, 12'h050, 12'h333, 12'h998, 12'h544};
    pc = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b0};
    py = '{12'h444, 12'h002, 12'h100, 12'h111, 12'h999, 12'h000};
    for (int i = 0; i < 6; i++) begin
      A   = pa[i];
      B   = pb[i];
      Cin = pc[i];
      @(posedge clk);
      #1;
      check($sformatf("pipe_%0d", i), py[i], (i == 1 || i == 3 || i == 5) ? 1'b1 : 1'b0);
    end

    // Mid-stream asynchronous reset
    apply_check("pre_reset", 12'h999, 12'h999, 1'b1, 12'h999, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 12'h000, 1'b0);
    @(posedge clk);
    #1;
    check("async_hold", 12'h000, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset", 12'h999, 1'b1);

    // Exhaustive single-digit pairs with carry-in on the units cell
    for (int a = 0; a < 10; a++) begin
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < 2; c++) begin
          sum = a + b + c;
          apply_check($sformatf("digit_%0d_%0d_%0d", a, b, c),
                      12'(a), 12'(b), c[0], to_bcd(sum), 1'b0);
        end
      end
    end

    // Random valid 3-digit operands against the decimal model
    for (int i = 0; i < 200; i++) begin
      ra  = to_bcd(int'($urandom_range(999, 0)));
      rb  = to_bcd(int'($urandom_range(999, 0)));
      rc  = 1'($urandom_range(1, 0));
      sum = bcd_val(ra) + bcd_val(rb) + int'(rc);
      apply_check($sformatf("rand_%0d", i), ra, rb, rc, to_bcd(sum % 1000), (sum >= 1000) ? 1'b1 : 1'b0);
    end

    // Random raw nibbles (may be non-decimal) against the digit rule
    for (int i = 0; i < 50; i++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      rc = 1'($urandom_range(1, 0));
      rr = rule_add(ra, rb, rc);
      apply_check($sformatf("raw_%0d", i), ra, rb, rc, rr[11:0], rr[12]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
